// File: rtl/fetch_bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_bpu_pkg
// Purpose  : Shared constants and types for the fetch-stage branch
//            pre-decoder / static predictor and its return address stack.
// Contents : RV32I control-flow opcodes, link-register indices, widths,
//            instruction class enum and a link-register helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_bpu_pkg;

  localparam int INSTR_WIDTH   = 32;
  localparam int REG_IDX_WIDTH = 5;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // x1 (ra) and x5 (t0) are the RISC-V link registers for RAS hinting
  localparam logic [REG_IDX_WIDTH-1:0] LINK_REG_X1 = 5'd1;
  localparam logic [REG_IDX_WIDTH-1:0] LINK_REG_X5 = 5'd5;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BXX  = 2'd1,
    CLS_JAL  = 2'd2,
    CLS_JALR = 2'd3
  } instr_cls_e;

  function automatic logic is_link_reg(input logic [REG_IDX_WIDTH-1:0] idx);
    return (idx == LINK_REG_X1) || (idx == LINK_REG_X5);
  endfunction

endpackage : fetch_bpu_pkg
`default_nettype wire

// File: rtl/fetch_ras.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ras
// Purpose  : Circular return address stack with saturating occupancy count.
//            Push when full overwrites the oldest entry; pop when empty is
//            ignored; push and pop together replace the top entry (or push
//            if the stack is empty).
// Ports    : clk_i, rst_n_i      clock / asynchronous active-low reset
//            push_i, pop_i       update requests (single cycle)
//            push_data_i [XLEN]  return address to store
//            top_o [XLEN]        current top-of-stack entry
//            empty_o             no valid entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  entries_q [RAS_DEPTH];
  logic [XLEN-1:0]  entries_d [RAS_DEPTH];

  always_comb begin
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (push_i && pop_i && (count_q != '0)) begin
      // call-and-return: swap the return address in place
      entries_d[top_ptr_q] = push_data_i;
    end else if (push_i) begin
      // RAS_DEPTH is a power of two, so the pointer wraps by overflow
      top_ptr_d            = top_ptr_q + PTR_W'(1);
      entries_d[top_ptr_d] = push_data_i;
      if (count_q != CNT_FULL) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_i && (count_q != '0)) begin
      top_ptr_d = top_ptr_q - PTR_W'(1);
      count_d   = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry contents are meaningless while count is zero, so no reset needed
  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
  end

  assign top_o   = entries_q[top_ptr_q];
  assign empty_o = (count_q == '0);

endmodule : fetch_ras
`default_nettype wire

// File: rtl/fetch_bpu.sv
`default_nettype none
// ============================================================================
// Module   : fetch_bpu
// Purpose  : Fetch-stage branch pre-decoder and static next-PC predictor.
//            Classifies bxx/jal/jalr, extracts the sign-extended immediate,
//            predicts taken/target (BTFN for branches, RAS for returns) and
//            registers everything into one valid/ready output stage.
// Ports    : clk_i, rst_n_i            clock / async active-low reset
//            flush_i                   drop the output stage, block accept
//            in_valid_i/in_ready_o     input handshake, pc_i, instr_i
//            out_valid_o/out_ready_i   output handshake
//            out_pc_o, out_instr_o     registered PC / instruction
//            dec_bxx_o/jal_o/jalr_o    instruction class
//            dec_bjp_imm_o             B/J/I immediate (0 for other opcodes)
//            jalr_rs1_idx_o            instr[19:15]
//            pred_taken_o, pred_target_o, need_rs1_o   prediction
//            ras_empty_o               RAS holds no entries (live)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_bpu
  import fetch_bpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter bit BTFN_EN   = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [INSTR_WIDTH-1:0]   instr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [INSTR_WIDTH-1:0]   out_instr_o,
  output logic                     dec_bxx_o,
  output logic                     dec_jal_o,
  output logic                     dec_jalr_o,
  output logic [XLEN-1:0]          dec_bjp_imm_o,
  output logic [REG_IDX_WIDTH-1:0] jalr_rs1_idx_o,
  output logic                     pred_taken_o,
  output logic [XLEN-1:0]          pred_target_o,
  output logic                     need_rs1_o,
  output logic                     ras_empty_o
);

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  instr_cls_e               cls;
  logic [REG_IDX_WIDTH-1:0] rd_idx;
  logic [REG_IDX_WIDTH-1:0] rs1_idx;
  logic [XLEN-1:0]          imm_b, imm_j, imm_i, imm;
  logic                     rd_link, rs1_link, is_call, is_ret;

  assign rd_idx  = instr_i[11:7];
  assign rs1_idx = instr_i[19:15];

  assign imm_b = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign imm_i = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};

  always_comb begin
    cls = CLS_NONE;
    case (instr_i[6:0])
      OPC_BRANCH: cls = CLS_BXX;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      default:    cls = CLS_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (cls)
      CLS_BXX:  imm = imm_b;
      CLS_JAL:  imm = imm_j;
      CLS_JALR: imm = imm_i;
      default:  imm = '0;
    endcase
  end

  assign rd_link  = is_link_reg(rd_idx);
  assign rs1_link = is_link_reg(rs1_idx);
  assign is_call  = ((cls == CLS_JAL) || (cls == CLS_JALR)) && rd_link;
  // jalr rd==rs1==link is a coroutine-style swap: treat it as a call only
  assign is_ret   = (cls == CLS_JALR) && rs1_link &&
                    !(rd_link && (rd_idx == rs1_idx));

  // --------------------------------------------------------------------------
  // Static prediction
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] pc_plus4, pc_plus_imm, ras_top, target;
  logic            ras_empty, taken, need_rs1;

  assign pc_plus4    = pc_i + XLEN'(4);
  assign pc_plus_imm = pc_i + imm;

  always_comb begin
    taken    = 1'b0;
    need_rs1 = 1'b0;
    target   = pc_plus4;
    case (cls)
      CLS_JAL: begin
        taken  = 1'b1;
        target = pc_plus_imm;
      end
      CLS_BXX: begin
        // negative offset means backward branch, typically a loop
        taken = BTFN_EN && imm[XLEN-1];
        if (taken) begin
          target = pc_plus_imm;
        end
      end
      CLS_JALR: begin
        if (is_ret && !ras_empty) begin
          taken  = 1'b1;
          target = ras_top;
        end else begin
          need_rs1 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and return address stack
  // --------------------------------------------------------------------------
  logic accept;

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  fetch_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (accept && is_call),
    .pop_i       (accept && is_ret),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign ras_empty_o = ras_empty;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic                     out_valid_q, out_valid_d;
  logic [XLEN-1:0]          out_pc_q, out_pc_d;
  logic [INSTR_WIDTH-1:0]   out_instr_q, out_instr_d;
  logic                     dec_bxx_q, dec_bxx_d;
  logic                     dec_jal_q, dec_jal_d;
  logic                     dec_jalr_q, dec_jalr_d;
  logic [XLEN-1:0]          dec_imm_q, dec_imm_d;
  logic [REG_IDX_WIDTH-1:0] rs1_idx_q, rs1_idx_d;
  logic                     pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]          pred_target_q, pred_target_d;
  logic                     need_rs1_q, need_rs1_d;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    dec_bxx_d     = dec_bxx_q;
    dec_jal_d     = dec_jal_q;
    dec_jalr_d    = dec_jalr_q;
    dec_imm_d     = dec_imm_q;
    rs1_idx_d     = rs1_idx_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    need_rs1_d    = need_rs1_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_pc_d      = pc_i;
      out_instr_d   = instr_i;
      dec_bxx_d     = (cls == CLS_BXX);
      dec_jal_d     = (cls == CLS_JAL);
      dec_jalr_d    = (cls == CLS_JALR);
      dec_imm_d     = imm;
      rs1_idx_d     = rs1_idx;
      pred_taken_d  = taken;
      pred_target_d = target;
      need_rs1_d    = need_rs1;
    end else if (flush_i || out_ready_i) begin
      // payload is left in place; only the valid bit is dropped
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      dec_bxx_q     <= 1'b0;
      dec_jal_q     <= 1'b0;
      dec_jalr_q    <= 1'b0;
      dec_imm_q     <= '0;
      rs1_idx_q     <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      need_rs1_q    <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      dec_bxx_q     <= dec_bxx_d;
      dec_jal_q     <= dec_jal_d;
      dec_jalr_q    <= dec_jalr_d;
      dec_imm_q     <= dec_imm_d;
      rs1_idx_q     <= rs1_idx_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      need_rs1_q    <= need_rs1_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_pc_o       = out_pc_q;
  assign out_instr_o    = out_instr_q;
  assign dec_bxx_o      = dec_bxx_q;
  assign dec_jal_o      = dec_jal_q;
  assign dec_jalr_o     = dec_jalr_q;
  assign dec_bjp_imm_o  = dec_imm_q;
  assign jalr_rs1_idx_o = rs1_idx_q;
  assign pred_taken_o   = pred_taken_q;
  assign pred_target_o  = pred_target_q;
  assign need_rs1_o     = need_rs1_q;

endmodule : fetch_bpu
`default_nettype wire

// File: tb/tb_fetch_bpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_bpu
// Purpose  : Self-checking bench for fetch_bpu: directed decode vectors,
//            hand-written RAS / backpressure / flush / reset sequences and
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_bpu;

  localparam int XLEN      = 32;
  localparam int RAS_DEPTH = 4;
  localparam bit BTFN      = 1'b1;

  logic        clk_i, rst_n_i, flush_i, in_valid_i, in_ready_o;
  logic [31:0] pc_i, instr_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_pc_o, out_instr_o, dec_bjp_imm_o, pred_target_o;
  logic        dec_bxx_o, dec_jal_o, dec_jalr_o, pred_taken_o, need_rs1_o;
  logic        ras_empty_o;
  logic [4:0]  jalr_rs1_idx_o;

  fetch_bpu #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH),
    .BTFN_EN   (BTFN)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .pc_i           (pc_i),
    .instr_i        (instr_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_instr_o    (out_instr_o),
    .dec_bxx_o      (dec_bxx_o),
    .dec_jal_o      (dec_jal_o),
    .dec_jalr_o     (dec_jalr_o),
    .dec_bjp_imm_o  (dec_bjp_imm_o),
    .jalr_rs1_idx_o (jalr_rs1_idx_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .need_rs1_o     (need_rs1_o),
    .ras_empty_o    (ras_empty_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: decoded record per instruction, RAS as a queue
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bxx, jal, jalr;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic        taken;
    logic [31:0] target;
    logic        need;
    logic        call, ret;
  } exp_t;

  exp_t        m;
  logic [31:0] ras[$];

  function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] ins,
                                   input int ras_n, input logic [31:0] ras_top);
    exp_t e;
    int   off;
    logic rd_l, rs1_l;
    e       = '0;
    e.pc    = pc;
    e.instr = ins;
    e.rs1   = ins[19:15];
    off     = 0;
    case (ins[6:0])
      7'b1100011: begin
        e.bxx = 1'b1;
        off = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0)
            + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]);
      end
      7'b1101111: begin
        e.jal = 1'b1;
        off = (ins[31] ? -1048576 : 0) + 4096 * int'(ins[19:12])
            + (ins[20] ? 2048 : 0) + 2 * int'(ins[30:21]);
      end
      7'b1100111: begin
        e.jalr = 1'b1;
        off = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
      end
      default: ;
    endcase
    e.imm  = 32'(off);
    rd_l   = (ins[11:7] == 5'd1) || (ins[11:7] == 5'd5);
    rs1_l  = (ins[19:15] == 5'd1) || (ins[19:15] == 5'd5);
    e.call = (e.jal || e.jalr) && rd_l;
    e.ret  = e.jalr && rs1_l && !(rd_l && (ins[11:7] == ins[19:15]));
    e.target = pc + 32'd4;
    if (e.jal) begin
      e.taken  = 1'b1;
      e.target = pc + e.imm;
    end else if (e.bxx) begin
      e.taken = BTFN && (off < 0);
      if (e.taken) e.target = pc + e.imm;
    end else if (e.jalr) begin
      if (e.ret && ras_n > 0) begin
        e.taken  = 1'b1;
        e.target = ras_top;
      end else begin
        e.need = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void ras_update(input logic call, input logic ret, input logic [31:0] la);
    if (call && ret && ras.size() > 0) begin
      ras[ras.size()-1] = la;
    end else if (call) begin
      ras.push_back(la);
      if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
    end else if (ret && ras.size() > 0) begin
      void'(ras.pop_back());
    end
  endfunction

  task automatic check_all(input string t);
    chk({t, ".out_valid"},  32'(out_valid_o),    32'(m.valid));
    chk({t, ".out_pc"},     out_pc_o,            m.pc);
    chk({t, ".out_instr"},  out_instr_o,         m.instr);
    chk({t, ".bxx"},        32'(dec_bxx_o),      32'(m.bxx));
    chk({t, ".jal"},        32'(dec_jal_o),      32'(m.jal));
    chk({t, ".jalr"},       32'(dec_jalr_o),     32'(m.jalr));
    chk({t, ".imm"},        dec_bjp_imm_o,       m.imm);
    chk({t, ".rs1_idx"},    32'(jalr_rs1_idx_o), 32'(m.rs1));
    chk({t, ".taken"},      32'(pred_taken_o),   32'(m.taken));
    chk({t, ".target"},     pred_target_o,       m.target);
    chk({t, ".need_rs1"},   32'(need_rs1_o),     32'(m.need));
    chk({t, ".ras_empty"},  32'(ras_empty_o),    32'(ras.size() == 0));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
    exp_t nx;
    logic exp_rdy;
    in_valid_i  = v;
    pc_i        = pc;
    instr_i     = ins;
    out_ready_i = rdy;
    flush_i     = fl;
    #1;
    exp_rdy = !fl && (!m.valid || rdy);
    chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    nx = predict(pc, ins, ras.size(), (ras.size() > 0) ? ras[ras.size()-1] : 32'h0);
    @(posedge clk_i);
    if (v && exp_rdy) begin
      m       = nx;
      m.valid = 1'b1;
      ras_update(nx.call, nx.ret, pc + 32'd4);
    end else if (fl || (m.valid && rdy)) begin
      m.valid = 1'b0;
    end
    @(negedge clk_i);
    check_all("step");
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    pc_i        = '0;
    instr_i     = '0;
    #1;
    m = '0;
    ras.delete();
    check_all("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd1;
      1:       return 5'd5;
      2:       return 5'd0;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w        = $urandom;
    w[11:7]  = pick_reg();
    w[19:15] = pick_reg();
    case ($urandom_range(0, 4))
      0:       w[6:0] = 7'b1100011;
      1:       w[6:0] = 7'b1101111;
      2, 3:    w[6:0] = 7'b1100111;
      default: ;
    endcase
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Directed decode table: {pc, instr, class(bxx,jal,jalr), imm, taken, target, need}
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  cls;
    logic [31:0] imm;
    logic        taken;
    logic [31:0] target;
    logic        need;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{32'h0000_0100, 32'hFE00_0EE3, 3'b100, 32'hFFFF_FFFC, 1'b1, 32'h0000_00FC, 1'b0};
    vt[1] = '{32'h0000_0100, 32'h0000_0463, 3'b100, 32'h0000_0008, 1'b0, 32'h0000_0104, 1'b0};
    vt[2] = '{32'h0000_0200, 32'h0400_00EF, 3'b010, 32'h0000_0040, 1'b1, 32'h0000_0240, 1'b0};
    vt[3] = '{32'h0000_1000, 32'hFF9F_F06F, 3'b010, 32'hFFFF_FFF8, 1'b1, 32'h0000_0FF8, 1'b0};
    vt[4] = '{32'h0000_0240, 32'h0000_8067, 3'b001, 32'h0000_0000, 1'b0, 32'h0000_0244, 1'b1};
    vt[5] = '{32'h0000_0300, 32'h0101_00E7, 3'b001, 32'h0000_0010, 1'b0, 32'h0000_0304, 1'b1};
    vt[6] = '{32'h0000_0400, 32'hFFC2_8067, 3'b001, 32'hFFFF_FFFC, 1'b0, 32'h0000_0404, 1'b1};
    vt[7] = '{32'h0000_0500, 32'h0010_0093, 3'b000, 32'h0000_0000, 1'b0, 32'h0000_0504, 1'b0};
    vt[8] = '{32'h0000_0000, 32'hFE00_0EE3, 3'b100, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vt[9] = '{32'hFFFF_FFFC, 32'h0000_0013, 3'b000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      do_reset();
      step(1'b1, vt[i].pc, vt[i].instr, 1'b1, 1'b0);
      chk($sformatf("vec%0d.class", i), 32'({dec_bxx_o, dec_jal_o, dec_jalr_o}), 32'(vt[i].cls));
      chk($sformatf("vec%0d.imm", i),    dec_bjp_imm_o,       vt[i].imm);
      chk($sformatf("vec%0d.taken", i),  32'(pred_taken_o),   32'(vt[i].taken));
      chk($sformatf("vec%0d.target", i), pred_target_o,       vt[i].target);
      chk($sformatf("vec%0d.need", i),   32'(need_rs1_o),     32'(vt[i].need));
    end

    // Call then return through the RAS
    do_reset();
    step(1'b1, 32'h200, 32'h0400_00EF, 1'b1, 1'b0);
    chk("callret.call_target", pred_target_o, 32'h240);
    chk("callret.ras_nonempty", 32'(ras_empty_o), 32'd0);
    step(1'b1, 32'h240, 32'h0000_8067, 1'b1, 1'b0);
    chk("callret.ret_taken", 32'(pred_taken_o), 32'd1);
    chk("callret.ret_target", pred_target_o, 32'h204);
    chk("callret.ras_empty", 32'(ras_empty_o), 32'd1);

    // Overflow: five calls into a four-deep RAS, then five returns
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(i * 16), 32'h0400_00EF, 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'(32'h800 + 4 * k), 32'h0000_8067, 1'b1, 1'b0);
      chk($sformatf("ovf.ret%0d_taken", k), 32'(pred_taken_o), 32'd1);
      chk($sformatf("ovf.ret%0d_target", k), pred_target_o, 32'(32'h44 - 16 * k));
    end
    step(1'b1, 32'h810, 32'h0000_8067, 1'b1, 1'b0);
    chk("ovf.ret4_taken", 32'(pred_taken_o), 32'd0);
    chk("ovf.ret4_need", 32'(need_rs1_o), 32'd1);
    chk("ovf.ret4_target", pred_target_o, 32'h814);

    // Backpressure: stalled output must not accept nor touch the RAS
    do_reset();
    step(1'b1, 32'h100, 32'h0000_0463, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h200, 32'h0400_00EF, 1'b0, 1'b0);
      chk("bp.in_ready", 32'(in_ready_o), 32'd0);
      chk("bp.hold_pc", out_pc_o, 32'h100);
      chk("bp.hold_instr", out_instr_o, 32'h0000_0463);
      chk("bp.ras_empty", 32'(ras_empty_o), 32'd1);
    end
    step(1'b1, 32'h200, 32'h0400_00EF, 1'b1, 1'b0);
    chk("bp.release_pc", out_pc_o, 32'h200);
    chk("bp.release_ras", 32'(ras_empty_o), 32'd0);

    // Flush while stalled, with a valid call offered that must be ignored
    step(1'b1, 32'h300, 32'h0400_00EF, 1'b0, 1'b1);
    chk("flush.valid", 32'(out_valid_o), 32'd0);
    step(1'b1, 32'h400, 32'h0000_8067, 1'b1, 1'b0);
    chk("flush.ras_top", pred_target_o, 32'h204);

    // Asynchronous reset between clock edges
    step(1'b1, 32'h500, 32'h0400_00EF, 1'b0, 1'b0);
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    m = '0;
    ras.delete();
    chk("areset.valid", 32'(out_valid_o), 32'd0);
    chk("areset.pc", out_pc_o, 32'd0);
    chk("areset.target", pred_target_o, 32'd0);
    chk("areset.ras_empty", 32'(ras_empty_o), 32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    in_valid_i = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 3) != 0),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           rand_instr(),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_bpu
`default_nettype wire

// File: doc/fetch_bpu.md
Name: fetch_bpu

Overview:
- Fetch-stage branch pre-decoder and static next-PC predictor with a return address stack (RAS).
- Takes one fetched 32-bit instruction per accepted handshake and classifies it as bxx, jal or jalr.
- Produces the sign-extended immediate, a taken/not-taken prediction and a predicted target.
- Registers all results into a single output stage, with valid/ready flow control on both sides.

Parameters:
- XLEN, 32, datapath and PC width.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.
- BTFN_EN, 1, conditional branch policy: 1 = backward-taken/forward-not-taken; 0 = always not-taken.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush (mispredict/exception); drops the output stage
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  block can accept an instruction
- pc_i  in  XLEN  PC of instr_i
- instr_i  in  32  fetched instruction
- out_valid_o  out  1  output stage holds a result
- out_ready_i  in  1  consumer accepts the result
- out_pc_o  out  XLEN  registered PC
- out_instr_o  out  32  registered instruction
- dec_bxx_o / dec_jal_o / dec_jalr_o  out  1 each  instruction class
- dec_bjp_imm_o  out  XLEN  sign-extended B/J/I immediate
- jalr_rs1_idx_o  out  5  instr[19:15]
- pred_taken_o  out  1  predicted redirect
- pred_target_o  out  XLEN  predicted next PC
- need_rs1_o  out  1  jalr target cannot be predicted; the consumer must read rs1
- ras_empty_o  out  1  RAS holds no valid entries (combinational from count)

Behaviour:
- Reset, asynchronous active low:
  - out_valid_o = 0 and every registered output = 0.
  - RAS count = 0 and top pointer = 0; entry contents are don't-care.
- Decode on opcode instr[6:0]:
  - 7'b1100011 → bxx, 7'b1101111 → jal, 7'b1100111 → jalr; any other opcode → none.
  - Immediates follow the RV32I B, J and I formats, sign-extended from instr[31] to XLEN. B and J immediates have bit0 = 0.
  - Exactly one class flag is set, or none.
- Link register: rd or rs1 ∈ {x1, x5}.
  - call = (jal|jalr) with rd link.
  - ret = jalr with rs1 link, excluding the case where rd is link and rd == rs1.
- Prediction, in priority order:
  - jal: taken = 1, target = pc + imm.
  - bxx: taken = BTFN_EN & imm[XLEN-1], target = pc + imm when taken, else pc + 4.
  - jalr ret with RAS non-empty: taken = 1, target = RAS top.
  - jalr in any other case (including ret with RAS empty): taken = 0, need_rs1 = 1, target = pc + 4.
  - none: taken = 0, target = pc + 4.
  - Adders wrap modulo 2^XLEN.
- Handshake:
  - in_ready_o = !flush_i & (!out_valid_o | out_ready_i).
  - Accept = in_valid_i & in_ready_o. On accept, the output register loads next cycle (latency 1) and out_valid_o = 1.
  - Output leaves when out_valid_o & out_ready_i with no new accept; then out_valid_o = 0.
  - While out_valid_o & !out_ready_i, all outputs hold stable.
- RAS update, only on accept:
  - call only: push pc + 4.
  - ret only: pop.
  - call & ret: replace the top entry with pc + 4; count unchanged. If the RAS is empty, this acts as a push.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change.
- Flush:
  - flush_i = 1 clears out_valid_o next cycle; no accept occurs that cycle.
  - RAS contents and pointers are not restored.
  - Flush has priority over out_ready_i.
- Reset mid-operation: immediate clear, with no partial RAS state.

Decomposition:
- Shared package:
  - opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR.
  - link-register indices 1 and 5.
  - INSTR_WIDTH and REG_IDX_WIDTH.
- Sub-module fetch_ras, parametrised on XLEN and RAS_DEPTH:
  - Inputs: push, pop, push_data.
  - Outputs: top, empty.
  - Internal: circular pointer and saturating count.
- Decode and prediction logic stays combinational inside fetch_bpu.

Test Plan:
- Backward branch: pc = 0x100, instr = 0xFE000EE3 (beq x0,x0,-4), BTFN_EN = 1 → one cycle later dec_bxx_o = 1, imm = 0xFFFFFFFC, pred_taken_o = 1, target = 0xFC.
- Forward branch: pc = 0x100, beq offset +8 → pred_taken_o = 0, target = 0x104.
- Call then return: jal x1,+0x40 at pc 0x200 (target 0x240, RAS top 0x204), then jalr x0,0(x1) at 0x240 → pred_taken_o = 1, target = 0x204, ras_empty_o = 1 afterwards.
- RAS overflow: RAS_DEPTH = 4, calls at pcs 0x0, 0x10, 0x20, 0x30, 0x40, then 5 returns → targets 0x44, 0x34, 0x24, 0x14, then a 5th ret with need_rs1_o = 1 and pred_taken_o = 0.
- Backpressure: hold out_ready_i = 0 for 3 cycles with in_valid_i = 1 → in_ready_o = 0, outputs stable, no RAS change; release → next instruction accepted.
- Flush and reset: flush_i with out_valid_o = 1 and out_ready_i = 0 → out_valid_o = 0 next cycle, RAS unchanged. Assert rst_n_i mid-stream → outputs 0 and ras_empty_o = 1 asynchronously.
